axi_burst_sram_slave: RTL
=========================

Name: axi_burst_sram_slave

Overview:
Parametrised AXI4 burst slave backed by an internal word-addressed memory array. It is the successor to the fixed-width CPU-side memory model that sits on the core's io_master port. It adds configurable data width, depth and read latency, FIXED/INCR/WRAP bursts, and error responses. Independent read and write engines run concurrently against one behavioural array.

Parameters:
DATA_W, 64, data bus width in bits (power of 2, 32..128)
ADDR_W, 32, address width
ID_W, 4, AXI ID width
DEPTH_LOG2, 16, log2 of array depth in DATA_W words
BASE_ADDR, 32'h8000_0000, first mapped byte address
RD_LAT, 1, wait cycles before each read beat (0..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
awvalid/awready  in/out  1  write address handshake
awid  in  ID_W; awaddr  in  ADDR_W; awlen  in  8; awsize  in  3; awburst  in  2
wvalid/wready  in/out  1  write data handshake
wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1
bvalid/bready  out/in  1  write response handshake
bid  out  ID_W; bresp  out  2
arvalid/arready  in/out  1  read address handshake
arid  in  ID_W; araddr  in  ADDR_W; arlen  in  8; arsize  in  3; arburst  in  2
rvalid/rready  out/in  1  read data handshake
rid  out  ID_W; rdata  out  DATA_W; rresp  out  2; rlast  out  1

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high. All registered outputs reset to 0, including awready, arready, wready, bvalid, rvalid, rlast, rdata, bresp and rresp. Array contents are not reset.
- A reset asserted mid-burst aborts both engines; they return to IDLE. Beats already written stay in the array.
- Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
  - W_IDLE -> W_DATA on AW handshake. AWID, address, len, size and burst are latched; the beat counter is set to 0.
  - Each W handshake commits the strobed bytes in the same cycle and advances the address.
  - After beat awlen+1: go to W_RESP. If wlast mismatches the count (early or missing), bresp=SLVERR.
  - W_RESP -> W_IDLE on bready. bid equals the latched awid. bvalid/bid/bresp are held until bready.
- Read FSM states: R_IDLE (arready=1), R_WAIT, R_DATA (rvalid=1).
  - R_IDLE -> R_WAIT on AR handshake; if RD_LAT=0 it goes to R_DATA instead.
  - R_WAIT counts RD_LAT cycles, then moves to R_DATA.
  - rdata is sampled from the array on entry to R_DATA. It is held stable while rvalid && !rready.
  - On handshake: if it was the last beat (rlast=1) go to R_IDLE, else R_WAIT (or R_DATA when RD_LAT=0).
  - rid equals the latched arid.
- Address arithmetic: beat bytes B = 1<<size. Array index = (addr-BASE_ADDR)>>log2(DATA_W/8).
  - FIXED: address is unchanged between beats.
  - INCR: addr += B. An unaligned first address aligns to B after the first beat.
  - WRAP: container = B*(len+1), aligned down. addr = base + ((addr+B) mod container).
- Errors:
  - size > log2(DATA_W/8), WRAP with len not in {1,3,7,15}, or burst=2'b11 gives SLVERR (2'b10) for the whole burst.
  - Any beat outside [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2*DATA_W/8) gives DECERR (2'b11).
  - Erroring write beats do not modify the array; erroring read beats return rdata=0.
  - All beats are still transferred. rresp is per beat; bresp is the worst response seen across the burst.
- Concurrency: a read and a write to the same word in the same cycle returns pre-write data. A write committed before the R_DATA entry cycle is visible.
- Only one outstanding transaction per direction. awready/arready are 0 outside their IDLE state.

Test Plan:
- Reset then single beat: INCR, len=0, size=3, awaddr=0x8000_0010, wdata=0x1122334455667788, wstrb=0xFF. Expect bresp=0 one cycle after the W handshake. A read of the same address returns that data with rlast=1, and rvalid appears RD_LAT cycles after the AR handshake.
- INCR len=3 at 0x8000_0000 with wstrb=0x0F on beat 2 only. Readback: beat 2 upper 4 bytes keep their old value; rlast only on beat 3.
- WRAP len=3 size=3 at 0x8000_0030: beat addresses 0x30, 0x38, 0x20, 0x28. WRAP len=2 gives SLVERR on all beats.
- Backpressure: rready held low 5 cycles with RD_LAT=0. rdata/rid stay stable and there is no beat loss. bready low 3 cycles keeps bvalid=1 and bid constant.
- araddr=0x7FFF_FFF8: rresp=DECERR, rdata=0. A write with wlast early on beat 1 of len=3 gives bresp=SLVERR.
- Assert rst during beat 2 of an 8-beat read. rvalid drops immediately, arready is 1 on the cycle after deassertion, and a new read completes normally.

Source files
------------

// File: rtl/axi_burst_sram_slave.sv
// AXI4 burst slave over a word-addressed behavioural array. Independent read and write
// engines share the array and support FIXED/INCR/WRAP bursts, read latency and error responses.
module axi_burst_sram_slave #(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 32,
    parameter int                ID_W       = 4,
    parameter int                DEPTH_LOG2 = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int              STRB_W    = DATA_W / 8;
    localparam int              OFF_BITS  = $clog2(STRB_W);
    localparam logic [2:0]      SZ_MAX    = 3'(OFF_BITS);
    localparam logic [ADDR_W:0] SPAN      = (ADDR_W+1)'(STRB_W) << DEPTH_LOG2;
    localparam logic [3:0]      WAIT_LAST = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);
    localparam logic [1:0]      OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;

    logic [DATA_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
        input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        logic [ADDR_W-1:0] b, container, wbase;
        b         = ADDR_W'(1) << size;
        container = b * (ADDR_W'(len) + ADDR_W'(1));
        wbase     = addr & ~(container - ADDR_W'(1));
        case (burst)
            2'b01:   next_addr = (addr & ~(b - ADDR_W'(1))) + b;
            2'b10:   next_addr = wbase | ((addr + b) & (container - ADDR_W'(1)));
            default: next_addr = addr;
        endcase
    endfunction

    // Burst-level protocol errors poison every beat of the burst with SLVERR.
    function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
        input logic [1:0] burst);
        burst_bad = (size > SZ_MAX) || (burst == 2'b11) ||
                    ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] addr, input logic bad);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        if (bad) beat_resp = SLVERR;
        else if ((addr < BASE_ADDR) || ({1'b0, off} >= SPAN)) beat_resp = DECERR;
        else beat_resp = OKAY;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        word_index = off[OFF_BITS +: DEPTH_LOG2];
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        worst = (a > b) ? a : b;
    endfunction

    // Write engine: valid/ready handshakes complete on any rising edge where both are high.
    logic [1:0]        w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst, w_worst, w_resp, w_acc;
    logic              w_bad, w_fire, w_last;
    logic [DATA_W-1:0] w_merged;

    assign w_fire = (w_state == W_DATA) && wvalid && wready;
    assign w_last = (w_cnt == w_len);
    assign w_resp = beat_resp(w_addr, w_bad);
    assign w_acc  = worst(worst(w_worst, w_resp), (wlast == w_last) ? OKAY : SLVERR);

    always_comb begin
        w_merged = mem[word_index(w_addr)];
        for (int i = 0; i < STRB_W; i++)
            if (wstrb[i]) w_merged[i*8 +: 8] = wdata[i*8 +: 8];
    end

    always_ff @(posedge clk)
        if (w_fire && (w_resp == OKAY)) mem[word_index(w_addr)] <= w_merged;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;  awready <= 1'b0;  wready <= 1'b0;  bvalid <= 1'b0;
            bid     <= '0;      bresp   <= OKAY;  w_addr <= '0;    w_len  <= '0;
            w_cnt   <= '0;      w_size  <= '0;    w_burst <= '0;   w_worst <= OKAY;
            w_bad   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= 8'd0;
                        w_worst <= OKAY;
                        w_bad   <= burst_bad(awsize, awlen, awburst);
                    end
                end
                W_DATA: if (w_fire) begin
                    w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                    if (w_last) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= w_acc;
                        w_state <= W_RESP;
                    end else begin
                        w_worst <= w_acc;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: r_addr/r_cnt describe the beat currently loaded or about to be loaded.
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr, ld_addr;
    logic [7:0]        r_len, r_cnt, ld_cnt, ld_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, ld_resp;
    logic [3:0]        r_wcnt;
    logic              r_bad, ld_bad, r_load, r_fire, ar_fire;

    assign ar_fire = (r_state == R_IDLE) && arvalid && arready;
    assign r_fire  = (r_state == R_DATA) && rvalid && rready;

    always_comb begin
        r_load  = 1'b0;
        ld_addr = r_addr;
        ld_cnt  = r_cnt;
        ld_len  = r_len;
        ld_bad  = r_bad;
        case (r_state)
            R_IDLE: if (ar_fire && (RD_LAT == 0)) begin
                r_load  = 1'b1;
                ld_addr = araddr;
                ld_cnt  = 8'd0;
                ld_len  = arlen;
                ld_bad  = burst_bad(arsize, arlen, arburst);
            end
            R_WAIT: r_load = (r_wcnt == WAIT_LAST);
            R_DATA: if (r_fire && !rlast && (RD_LAT == 0)) begin
                r_load  = 1'b1;
                ld_addr = next_addr(r_addr, r_size, r_len, r_burst);
                ld_cnt  = r_cnt + 8'd1;
            end
            default: r_load = 1'b0;
        endcase
        ld_resp = beat_resp(ld_addr, ld_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;  arready <= 1'b0;  rvalid <= 1'b0;  rlast  <= 1'b0;
            rid     <= '0;      rdata   <= '0;    rresp  <= OKAY;  r_addr <= '0;
            r_len   <= '0;      r_cnt   <= '0;    r_size <= '0;    r_burst <= '0;
            r_wcnt  <= '0;      r_bad   <= 1'b0;
        end else begin
            if (r_load) begin
                rvalid  <= 1'b1;
                rdata   <= (ld_resp == OKAY) ? mem[word_index(ld_addr)] : '0;
                rresp   <= ld_resp;
                rlast   <= (ld_cnt == ld_len);
                r_state <= R_DATA;
            end
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_fire) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= 8'd0;
                        r_wcnt  <= 4'd0;
                        r_bad   <= burst_bad(arsize, arlen, arburst);
                        if (RD_LAT != 0) r_state <= R_WAIT;
                    end
                end
                R_WAIT: r_wcnt <= r_wcnt + 4'd1;
                R_DATA: if (r_fire) begin
                    r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
                    r_cnt  <= r_cnt + 8'd1;
                    r_wcnt <= 4'd0;
                    if (rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        r_state <= R_IDLE;
                    end else if (RD_LAT != 0) begin
                        rvalid  <= 1'b0;
                        r_state <= R_WAIT;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
